// File: rtl/mul_add_pkg.sv
// mul_add_pkg: shared types, widths and magnitude helper for the sequential multiply-add.
package mul_add_pkg;
  localparam int A_WIDTH_DEF = 64;
  localparam int B_WIDTH_DEF = 32;
  localparam int CNT_WIDTH = $clog2(B_WIDTH_DEF + 1);
  localparam int MAG_WIDTH = 64;
  typedef enum logic [1:0] {IDLE, LOOP, FIX, DONE} mul_state_t;
  function automatic logic [MAG_WIDTH-1:0] twos_mag(input logic [MAG_WIDTH-1:0] v);
    return v[MAG_WIDTH-1] ? -v : v;
  endfunction
endpackage

// File: rtl/mul_add.sv
// mul_add: shift-add signed multiply-add, product = multiplicand*multiplier + addend.
// Ports: clk, reset (async, active-high); valid_in + multiplicand/multiplier/addend in;
// busy, product, valid_out (one-cycle pulse), overflow out.
module mul_add
  import mul_add_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic [A_WIDTH-1:0] multiplicand,
  input  logic [B_WIDTH-1:0] multiplier,
  input  logic [B_WIDTH-1:0] addend,
  output logic               busy,
  output logic [A_WIDTH-1:0] product,
  output logic               valid_out,
  output logic               overflow
);
  localparam int P_W = A_WIDTH + B_WIDTH;
  localparam int CW = $clog2(B_WIDTH + 1);
  mul_state_t state_q, state_d;
  logic [P_W-1:0] acc_q, acc_d, sa_q, sa_d;
  logic [B_WIDTH-1:0] mb_q, mb_d, c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, overflow_q, overflow_d;
  logic [A_WIDTH-1:0] product_q, product_d, mag_a;
  logic [B_WIDTH-1:0] mag_b;
  logic [P_W:0] mag_acc, sgn_acc, c_ext, full;
  logic [B_WIDTH+1:0] top;
  // Most-negative operands map to 2^(W-1), which still fits the unsigned width.
  assign mag_a = A_WIDTH'(twos_mag(MAG_WIDTH'($signed(multiplicand))));
  assign mag_b = B_WIDTH'(twos_mag(MAG_WIDTH'($signed(multiplier))));
  // One extra bit so the signed full result never wraps before the overflow test.
  assign mag_acc = {1'b0, acc_q};
  assign sgn_acc = neg_q ? -mag_acc : mag_acc;
  assign c_ext = {{(P_W + 1 - B_WIDTH){c_q[B_WIDTH-1]}}, c_q};
  assign full = sgn_acc + c_ext;
  assign top = full[P_W:A_WIDTH-1];
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    sa_d = sa_q;
    mb_d = mb_q;
    c_d = c_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    product_d = product_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: if (valid_in) begin
        state_d = LOOP;
        sa_d = {{B_WIDTH{1'b0}}, mag_a};
        mb_d = mag_b;
        neg_d = multiplicand[A_WIDTH-1] ^ multiplier[B_WIDTH-1];
        c_d = addend;
        acc_d = '0;
        cnt_d = '0;
      end
      LOOP: begin
        acc_d = mb_q[0] ? acc_q + sa_q : acc_q;
        sa_d = sa_q << 1;
        mb_d = mb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(B_WIDTH - 1)) ? FIX : LOOP;
      end
      FIX: begin
        product_d = full[A_WIDTH-1:0];
        overflow_d = ~(&top | ~|top);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      sa_q <= '0;
      mb_q <= '0;
      c_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      product_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      sa_q <= sa_d;
      mb_q <= mb_d;
      c_q <= c_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      product_q <= product_d;
      overflow_q <= overflow_d;
    end
  end
  assign busy = state_q != IDLE;
  assign valid_out = state_q == DONE;
  assign product = product_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_mul_add.sv
// tb_mul_add: table-driven and scoreboard checks of mul_add latency, arithmetic and handshake.
module tb_mul_add;
  typedef struct {
    logic [63:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [63:0] p;
    logic        o;
  } vec_t;
  typedef struct {
    logic [63:0] p;
    logic        o;
  } exp_t;
  logic clk, reset, valid_in, busy, valid_out, overflow;
  logic [63:0] multiplicand, product;
  logic [31:0] multiplier, addend;
  int vectors = 0, miscompares = 0, cyc = 0;
  exp_t exp_q[$];
  exp_t sb_e;
  int vo_cyc[$];
  vec_t tbl[8];
  mul_add dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .multiplicand(multiplicand),
    .multiplier(multiplier), .addend(addend), .busy(busy), .product(product),
    .valid_out(valid_out), .overflow(overflow)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [63:0] a, input logic [31:0] b, input logic [31:0] c);
    logic signed [96:0] fa, fb, fc, f;
    exp_t r;
    fa = $signed(a);
    fb = $signed(b);
    fc = $signed(c);
    f = fa * fb + fc;
    r.p = f[63:0];
    r.o = !((&f[96:63]) || !(|f[96:63]));
    return r;
  endfunction
  always @(negedge clk) begin
    if (!reset && valid_out) begin
      vo_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got product %h with nothing pending", product);
      end else begin
        sb_e = exp_q.pop_front();
        check("product", product, sb_e.p);
        check("overflow", {63'b0, overflow}, {63'b0, sb_e.o});
      end
    end
  end
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'd0);
  endtask
  task automatic issue(input logic [63:0] a, input logic [31:0] b, input logic [31:0] c,
                       input exp_t e, input bit push);
    wait_idle();
    multiplicand = a;
    multiplier = b;
    addend = c;
    valid_in = 1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1 valid_in = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask
  initial begin
    exp_t e;
    int vk, bc, vc;
    logic [63:0] ra;
    logic [31:0] rb, rc;
    longint mb;
    tbl[0] = '{64'd7, 32'd3, 32'd2, 64'd23, 1'b0};
    tbl[1] = '{-64'sd7, 32'd3, -32'sd2, -64'sd23, 1'b0};
    tbl[2] = '{64'd5, -32'sd4, 32'd3, -64'sd17, 1'b0};
    tbl[3] = '{64'h8000_0000_0000_0000, -32'sd1, 32'd0, 64'h8000_0000_0000_0000, 1'b1};
    tbl[4] = '{64'd2, 32'h8000_0000, 32'd0, 64'hFFFF_FFFF_0000_0000, 1'b0};
    tbl[5] = '{64'd12345, 32'd0, -32'sd5, -64'sd5, 1'b0};
    tbl[6] = '{64'd0, -32'sd777, 32'd9, 64'd9, 1'b0};
    tbl[7] = '{64'h8000_0000_0000_0000, 32'd1, -32'sd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
    reset = 1;
    valid_in = 0;
    multiplicand = '0;
    multiplier = '0;
    addend = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_valid_out", 64'(valid_out), 64'd0);
    check("reset_product", product, 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    reset = 0;
    // latency and busy window of a single operation
    issue(tbl[0].a, tbl[0].b, tbl[0].c, '{tbl[0].p, tbl[0].o}, 1);
    vk = -1;
    bc = 0;
    vc = 0;
    for (int k = 0; k < 40; k++) begin
      if (valid_out) begin
        vc++;
        if (vk < 0) vk = k;
      end
      if (busy) bc++;
      @(posedge clk);
      #1;
    end
    check("valid_out_latency", 64'(vk), 64'd33);
    check("busy_cycles", 64'(bc), 64'd34);
    check("valid_out_pulses", 64'(vc), 64'd1);
    for (int i = 1; i < 8; i++) issue(tbl[i].a, tbl[i].b, tbl[i].c, '{tbl[i].p, tbl[i].o}, 1);
    drain();
    // valid_in held high: one result per 35 cycles, in order
    vo_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      wait_idle();
      multiplicand = 64'(1000 + i);
      multiplier = 32'(-(i + 2));
      addend = 32'(i);
      valid_in = 1;
      exp_q.push_back(model(multiplicand, multiplier, addend));
      @(posedge clk);
    end
    #1 valid_in = 0;
    drain();
    repeat (5) @(posedge clk);
    check("held_result_count", 64'(vo_cyc.size()), 64'd3);
    if (vo_cyc.size() == 3) begin
      check("issue_interval_0", 64'(vo_cyc[1] - vo_cyc[0]), 64'd35);
      check("issue_interval_1", 64'(vo_cyc[2] - vo_cyc[1]), 64'd35);
    end
    // valid_in pulses while busy are ignored
    vo_cyc.delete();
    issue(tbl[3].a, tbl[3].b, tbl[3].c, '{tbl[3].p, tbl[3].o}, 1);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      multiplicand = 64'(k);
      multiplier = 32'd9;
      valid_in = (k == 2 || k == 10 || k == 20 || k == 33);
    end
    @(posedge clk);
    #1 valid_in = 0;
    drain();
    repeat (40) @(posedge clk);
    check("busy_pulse_results", 64'(vo_cyc.size()), 64'd1);
    // reset in the middle of LOOP abandons the operation
    vo_cyc.delete();
    issue(64'd1234, 32'd567, 32'd0, e, 0);
    repeat (9) @(posedge clk);
    #1 reset = 1;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_valid_out", 64'(valid_out), 64'd0);
    check("midreset_product", product, 64'd0);
    check("midreset_overflow", 64'(overflow), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (40) @(posedge clk);
    check("midreset_no_result", 64'(vo_cyc.size()), 64'd0);
    issue(64'd100, -32'sd3, 32'd1, '{-64'sd299, 1'b0}, 1);
    drain();
    // round trip against the wide reference model, |c| < |b|
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      do rb = $urandom; while (rb == 0);
      mb = rb[31] ? -longint'($signed(rb)) : longint'(rb);
      rc = 32'($urandom_range(0, 32'(mb - 1)));
      if ($urandom_range(0, 1) == 1) rc = -rc;
      issue(ra, rb, rc, model(ra, rb, rc), 1);
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mul_add.md
Name: mul_add

Overview:
- Sequential signed multiply-add: computes result = multiplicand * multiplier + addend.
- Inverse companion of the team's shift-subtract divider; rebuilds dividend = quotient * divisor + remainder.
- Used for fixed-point gain/scale stages in the FM datapath and as the round-trip check for division results.
- Shift-add core, one multiplier bit per cycle, single operation in flight, valid/busy handshake.

Parameters:
- A_WIDTH, 64, width of multiplicand, addend-extended result and product output (signed).
- B_WIDTH, 32, width of multiplier and addend (signed).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- valid_in  in  1  operands valid; sampled only when busy=0.
- multiplicand  in  A_WIDTH  signed operand a.
- multiplier  in  B_WIDTH  signed operand b.
- addend  in  B_WIDTH  signed operand c; sign-extended to A_WIDTH.
- busy  out  1  high whenever the FSM is not IDLE.
- product  out  A_WIDTH  low A_WIDTH bits of a*b+c; registered and held until the next result.
- valid_out  out  1  one-cycle pulse when product/overflow update.
- overflow  out  1  true a*b+c is not representable in signed A_WIDTH bits; registered with product.

Behaviour:
- Reset values: busy=0, valid_out=0, product=0, overflow=0, FSM=IDLE, all internal registers 0.
- Reset asserted mid-operation: the operation is abandoned, no valid_out is produced, and the block returns to IDLE.
- FSM states and transitions:
  - IDLE: valid_in=1 at edge N captures operands and goes to LOOP.
  - LOOP: runs exactly B_WIDTH cycles, then goes to FIX.
  - FIX: one cycle, then DONE.
  - DONE: valid_out=1 for one cycle, then IDLE.
- Timing:
  - valid_out is high in the cycle after edge N+B_WIDTH+1 (cycle 33 after capture at defaults).
  - IDLE is re-entered at edge N+B_WIDTH+2.
  - Minimum issue interval is B_WIDTH+3 cycles (35 at defaults).
- valid_in while busy=1 is ignored: no queueing, no error flag. Operands need only be stable at the capture edge.
- Capture:
  - mag_a = |a| as an A_WIDTH-bit unsigned value; mag_b = |b| as B_WIDTH-bit unsigned.
  - The most-negative value yields magnitude 2^(W-1), which fits unsigned W bits.
  - neg = a[A_WIDTH-1] XOR b[B_WIDTH-1]; c is registered.
  - acc (A_WIDTH+B_WIDTH bits, unsigned) is cleared; the iteration counter (clog2(B_WIDTH+1) bits) is cleared.
- LOOP iteration (one per cycle):
  - If mag_b[0]=1, acc += mag_a shifted left by the count.
  - Equivalently: shift mag_b right by one and the shifted multiplicand register left by one.
  - The counter increments; leave LOOP when count reaches B_WIDTH-1 at the edge.
  - Fixed latency: no early termination, even when b=0.
- FIX:
  - full = (neg ? -acc : acc) + sext(c), computed in A_WIDTH+B_WIDTH+1 signed bits.
  - product <= full[A_WIDTH-1:0].
  - overflow <= 1 unless full[A_WIDTH+B_WIDTH:A_WIDTH-1] are all equal.
  - Outputs are registered here, so they are visible in DONE together with valid_out.
- b=0: product=c, overflow=0.
- a=0 with b arbitrary: product=c.
- product is held after DONE until the next FIX; overflow is held with it.

Decomposition:
- Shared arithmetic package holds:
  - mul_state_t enum {IDLE, LOOP, FIX, DONE}.
  - A helper function for two's-complement magnitude.
  - A localparam for the counter width, $clog2(B_WIDTH+1).
- No sub-module: the shift-add datapath and FSM fit in one module of roughly 150-200 lines.

Test Plan:
- Basic positive case: a=7, b=3, c=2 with one valid_in pulse -> product=23, overflow=0; valid_out pulses exactly 33 cycles after the capture edge; busy high for 34 cycles.
- Mixed signs: a=-7, b=3, c=-2 -> product=-23. Separately, a=5, b=-4, c=3 -> product=-17, overflow=0.
- Boundary operands:
  - a=-2^63, b=-1, c=0 -> product=0x8000_0000_0000_0000, overflow=1.
  - a=2, b=-2^31, c=0 -> product=-2^32, overflow=0.
  - b=0, c=-5 -> product=-5.
- Handshake: valid_in held high continuously with distinct operand sets -> exactly one result every 35 cycles, in order. valid_in pulses while busy produce no extra results.
- Reset mid-LOOP: assert reset at cycle 10 of an operation -> busy/valid_out/product/overflow go to 0 immediately and no valid_out follows. A following a=100, b=-3, c=1 yields -299.
- Round trip: 1000 random (a,b,c) with |c|<|b| -> product equals the reference model a*b+c truncated to 64 bits; overflow matches a 97-bit model.
